// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-port payload used by the register file.
package cpu_pkg;

  localparam int unsigned REGISTER_COUNT         = 32;
  localparam int unsigned REGISTER_ADDRESS_WIDTH = 5;
  localparam int unsigned REGISTER_DATA_WIDTH    = 32;

  localparam logic [REGISTER_DATA_WIDTH-1:0]    ZERO_WORD     = 32'h0;
  localparam logic [REGISTER_ADDRESS_WIDTH-1:0] ZERO_REGISTER = 5'd0;

  typedef logic [REGISTER_ADDRESS_WIDTH-1:0] register_address_t;
  typedef logic [REGISTER_DATA_WIDTH-1:0]    register_word_t;

  typedef struct packed {
    logic              enable;
    register_address_t address;
    register_word_t    data;
  } register_write_t;

endpackage

// File: rtl/register_read_port.sv
// One combinational read port: zero/disable gating, write-through bypass, stored word.
module register_read_port
  import cpu_pkg::*;
(
  input  logic              reset,
  input  logic              read_enable,
  input  register_address_t read_address,
  input  register_write_t   write_bus,
  input  register_word_t    stored_word,
  output register_word_t    read_data
);

  logic bypass_hit;

  assign bypass_hit = write_bus.enable && (write_bus.address == read_address);

  // Enable is tested first so an undefined address cannot leak through when idle.
  always_comb begin
    read_data = ZERO_WORD;
    if (reset || !read_enable) begin
      read_data = ZERO_WORD;
    end else if (read_address == ZERO_REGISTER) begin
      read_data = ZERO_WORD;
    end else if (bypass_hit) begin
      read_data = write_bus.data;
    end else begin
      read_data = stored_word;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32x32 register file with r0 hardwired to zero, one write port and two bypassed read ports.
module register_file
  import cpu_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              register_write_enable,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] register_write_address,
  input  logic [REGISTER_DATA_WIDTH-1:0]    register_write_data,
  input  logic                              register_read_enable_1,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] register_read_address_1,
  output logic [REGISTER_DATA_WIDTH-1:0]    register_read_data_1,
  input  logic                              register_read_enable_2,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] register_read_address_2,
  output logic [REGISTER_DATA_WIDTH-1:0]    register_read_data_2
);

  register_word_t  storage [REGISTER_COUNT];
  register_write_t write_bus;
  logic            write_commit;

  assign write_bus.enable  = register_write_enable;
  assign write_bus.address = register_write_address;
  assign write_bus.data    = register_write_data;

  assign write_commit = register_write_enable && (register_write_address != ZERO_REGISTER);

  // Reset wins over a simultaneous write; r0 is never written so it stays zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(REGISTER_COUNT); i++) begin
        storage[i] <= ZERO_WORD;
      end
    end else if (write_commit) begin
      storage[register_write_address] <= register_write_data;
    end
  end

  register_read_port u_read_port_1 (
    .reset        (reset),
    .read_enable  (register_read_enable_1),
    .read_address (register_read_address_1),
    .write_bus    (write_bus),
    .stored_word  (storage[register_read_address_1]),
    .read_data    (register_read_data_1)
  );

  register_read_port u_read_port_2 (
    .reset        (reset),
    .read_enable  (register_read_enable_2),
    .read_address (register_read_address_2),
    .write_bus    (write_bus),
    .stored_word  (storage[register_read_address_2]),
    .read_data    (register_read_data_2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: writes, bypass, r0, enables and reset behaviour.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic        register_write_enable;
  logic [4:0]  register_write_address;
  logic [31:0] register_write_data;
  logic        register_read_enable_1;
  logic [4:0]  register_read_address_1;
  logic [31:0] register_read_data_1;
  logic        register_read_enable_2;
  logic [4:0]  register_read_address_2;
  logic [31:0] register_read_data_2;

  int checks   = 0;
  int failures = 0;

  register_file dut (
    .clock                   (clock),
    .reset                   (reset),
    .register_write_enable   (register_write_enable),
    .register_write_address  (register_write_address),
    .register_write_data     (register_write_data),
    .register_read_enable_1  (register_read_enable_1),
    .register_read_address_1 (register_read_address_1),
    .register_read_data_1    (register_read_data_1),
    .register_read_enable_2  (register_read_enable_2),
    .register_read_address_2 (register_read_address_2),
    .register_read_data_2    (register_read_data_2)
  );

  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs change and outputs settle 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive_write(input logic en, input logic [4:0] addr, input logic [31:0] data);
    register_write_enable  = en;
    register_write_address = addr;
    register_write_data    = data;
  endtask

  task automatic drive_reads(input logic en1, input logic [4:0] a1, input logic en2, input logic [4:0] a2);
    register_read_enable_1  = en1;
    register_read_address_1 = a1;
    register_read_enable_2  = en2;
    register_read_address_2 = a2;
  endtask

  initial begin
    reset = 1'b1;
    drive_write(1'b1, 5'd5, 32'h0BAD_F00D);
    drive_reads(1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    settle();
    check("reset_p1_no_bypass", register_read_data_1, 32'h0);
    check("reset_p2_no_bypass", register_read_data_2, 32'h0);
    step();
    reset = 1'b0;
    drive_write(1'b0, 5'd0, 32'h0);
    drive_reads(1'b1, 5'd5, 1'b1, 5'd5);
    settle();
    check("post_reset_r5_discarded", register_read_data_1, 32'h0);

    // Write r5 then read it back on the following cycle.
    drive_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    drive_reads(1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive_write(1'b0, 5'd5, 32'h0);
    drive_reads(1'b1, 5'd5, 1'b0, 5'd0);
    settle();
    check("r5_readback", register_read_data_1, 32'hDEAD_BEEF);
    check("p2_disabled_zero", register_read_data_2, 32'h0);

    // Writes to r0 are ignored and r0 always reads zero.
    drive_write(1'b1, 5'd0, 32'h1234_5678);
    drive_reads(1'b1, 5'd0, 1'b1, 5'd0);
    settle();
    check("r0_write_cycle_p1", register_read_data_1, 32'h0);
    check("r0_write_cycle_p2", register_read_data_2, 32'h0);
    step();
    drive_write(1'b0, 5'd0, 32'h0);
    settle();
    check("r0_after_p1", register_read_data_1, 32'h0);
    check("r0_after_p2", register_read_data_2, 32'h0);

    // Same-cycle bypass to both ports, then stored value with write disabled.
    drive_write(1'b1, 5'd7, 32'hA5A5_A5A5);
    drive_reads(1'b1, 5'd7, 1'b1, 5'd7);
    settle();
    check("r7_bypass_p1", register_read_data_1, 32'hA5A5_A5A5);
    check("r7_bypass_p2", register_read_data_2, 32'hA5A5_A5A5);
    step();
    drive_write(1'b0, 5'd7, 32'h0);
    settle();
    check("r7_stored_p1", register_read_data_1, 32'hA5A5_A5A5);
    check("r7_stored_p2", register_read_data_2, 32'hA5A5_A5A5);

    // Bypass must not hit a different address.
    drive_write(1'b1, 5'd10, 32'h0000_00AA);
    drive_reads(1'b1, 5'd5, 1'b1, 5'd10);
    settle();
    check("no_bypass_other_addr", register_read_data_1, 32'hDEAD_BEEF);
    check("bypass_r10_p2", register_read_data_2, 32'h0000_00AA);
    step();
    drive_write(1'b0, 5'd10, 32'h5555_5555);
    settle();
    check("disabled_write_no_bypass", register_read_data_2, 32'h0000_00AA);
    step();
    settle();
    check("disabled_write_no_commit", register_read_data_2, 32'h0000_00AA);

    // Read enable gating on port 2.
    drive_write(1'b1, 5'd3, 32'h1);
    drive_reads(1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive_write(1'b0, 5'd0, 32'h0);
    drive_reads(1'b0, 5'd0, 1'b0, 5'd3);
    settle();
    check("r3_p2_disabled", register_read_data_2, 32'h0);
    register_read_enable_2 = 1'b1;
    settle();
    check("r3_p2_enabled", register_read_data_2, 32'h1);

    // Undefined address with enable low reads zero.
    register_read_enable_1  = 1'b0;
    register_read_address_1 = 5'bxxxxx;
    settle();
    check("x_addr_disabled", register_read_data_1, 32'h0);
    step();

    // Back-to-back writes to r4.
    drive_write(1'b1, 5'd4, 32'h11);
    drive_reads(1'b1, 5'd4, 1'b0, 5'd0);
    step();
    drive_write(1'b1, 5'd4, 32'h22);
    settle();
    check("r4_second_write_bypass", register_read_data_1, 32'h22);
    step();
    drive_write(1'b0, 5'd0, 32'h0);
    settle();
    check("r4_last_write", register_read_data_1, 32'h22);

    // Fill r1..r31 with their own index and verify through both ports.
    for (int i = 1; i < 32; i++) begin
      drive_write(1'b1, 5'(i), 32'(i));
      step();
    end
    drive_write(1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++) begin
      drive_reads(1'b1, 5'(i), 1'b1, 5'(32 - i));
      settle();
      check("fill_p1", register_read_data_1, 32'(i));
      check("fill_p2", register_read_data_2, 32'(32 - i));
    end

    // Reset with a simultaneous write to r9.
    reset = 1'b1;
    drive_write(1'b1, 5'd9, 32'hFFFF_FFFF);
    drive_reads(1'b1, 5'd9, 1'b1, 5'd31);
    settle();
    check("reset_mid_p1", register_read_data_1, 32'h0);
    check("reset_mid_p2", register_read_data_2, 32'h0);
    step();
    reset = 1'b0;
    drive_write(1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++) begin
      drive_reads(1'b1, 5'(i), 1'b1, 5'(32 - i));
      settle();
      check("cleared_p1", register_read_data_1, 32'h0);
      check("cleared_p2", register_read_data_2, 32'h0);
    end

    // Writes are accepted in the first cycle after reset deasserts.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_write(1'b1, 5'd2, 32'h0000_CAFE);
    drive_reads(1'b1, 5'd2, 1'b0, 5'd0);
    step();
    drive_write(1'b0, 5'd0, 32'h0);
    settle();
    check("first_cycle_after_reset_write", register_read_data_1, 32'h0000_CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
